// File: rtl/divider_pkg.sv
// rtl/divider_pkg.sv - shared state encoding and default width for the sequential divider
// Contents:
//   state_t        FSM state encoding (IDLE=0, CALC=1, DONE=2)
//   DEFAULT_WIDTH  default operand/result width
package divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational shift-subtract-restore iteration of a restoring divider
// Ports:
//   a_in   [WIDTH:0]    partial remainder before the iteration
//   q_in   [WIDTH-1:0]  dividend/quotient shift register before the iteration
//   m      [WIDTH-1:0]  divisor
//   a_out  [WIDTH:0]    partial remainder after the iteration
//   q_out  [WIDTH-1:0]  shift register after the iteration, new quotient bit in bit 0
import divider_pkg::*;

module div_step #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH:0]   a_in,
    input  logic [WIDTH-1:0] q_in,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH:0]   a_out,
    output logic [WIDTH-1:0] q_out
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // The partial remainder is always below m between iterations, so its top
    // bit is zero and is dropped by the shift.
    logic unused_a_msb;
    assign unused_a_msb = a_in[WIDTH];

    assign shifted = {a_in[WIDTH-1:0], q_in[WIDTH-1]};
    assign trial   = shifted - {1'b0, m};

    always_comb begin
        a_out = shifted;
        q_out = {q_in[WIDTH-2:0], 1'b0};
        // A clear borrow bit means the divisor fit: keep the difference.
        if (!trial[WIDTH]) begin
            a_out = trial;
            q_out = {q_in[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/divider_4bit_seq.sv
// rtl/divider_4bit_seq.sv - sequential unsigned restoring divider with Start/Done handshake
// Ports:
//   Clk        rising-edge clock
//   Rst_n      asynchronous active-low reset
//   Start      launch request, honoured only while idle
//   Dividend   unsigned dividend, sampled with an accepted Start
//   Divisor    unsigned divisor, sampled with an accepted Start
//   Quotient   registered quotient, held until the next completion
//   Remainder  registered remainder, held until the next completion
//   Busy       high while an operation is in flight
//   Done       one-cycle completion pulse
//   DivByZero  set when the last operation had a zero divisor
import divider_pkg::*;

module divider_4bit_seq #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Start,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH:0]   a_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] m_reg;
    logic [CNT_W-1:0] count;

    logic [WIDTH:0]   a_next;
    logic [WIDTH-1:0] q_next;

    div_step #(.WIDTH(WIDTH)) u_step (
        .a_in  (a_reg),
        .q_in  (q_reg),
        .m     (m_reg),
        .a_out (a_next),
        .q_out (q_next)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state     <= IDLE;
            a_reg     <= '0;
            q_reg     <= '0;
            m_reg     <= '0;
            count     <= '0;
            Quotient  <= '0;
            Remainder <= '0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            DivByZero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    Done <= 1'b0;
                    if (Start) begin
                        Busy <= 1'b1;
                        if (Divisor != '0) begin
                            m_reg <= Divisor;
                            q_reg <= Dividend;
                            a_reg <= '0;
                            count <= '0;
                            state <= CALC;
                        end else begin
                            // Zero divisor skips the iterations entirely.
                            Quotient  <= '1;
                            Remainder <= Dividend;
                            DivByZero <= 1'b1;
                            Done      <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                CALC: begin
                    a_reg <= a_next;
                    q_reg <= q_next;
                    count <= count + 1'b1;
                    if (count == LAST_ITER) begin
                        Quotient  <= q_next;
                        Remainder <= a_next[WIDTH-1:0];
                        DivByZero <= 1'b0;
                        Done      <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    Done  <= 1'b0;
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    Done  <= 1'b0;
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divider_4bit_seq.sv
// tb/tb_divider_4bit_seq.sv - self-checking bench for divider_4bit_seq
module tb_divider_4bit_seq;

    localparam int W = 4;

    logic         Clk = 1'b0;
    logic         Rst_n = 1'b0;
    logic         Start = 1'b0;
    logic [W-1:0] Dividend = '0;
    logic [W-1:0] Divisor = '0;
    logic [W-1:0] Quotient;
    logic [W-1:0] Remainder;
    logic         Busy;
    logic         Done;
    logic         DivByZero;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    divider_4bit_seq #(.WIDTH(W)) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .Start     (Start),
        .Dividend  (Dividend),
        .Divisor   (Divisor),
        .Quotient  (Quotient),
        .Remainder (Remainder),
        .Busy      (Busy),
        .Done      (Done),
        .DivByZero (DivByZero)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc++;

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: an operation occupies a fixed number of busy cycles
    // (W+1 normally, 1 for a zero divisor); Done is the last busy cycle and
    // the results appear at that moment.
    int         m_rem = 0;
    logic [W-1:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;
    logic       m_z = 1'b0, p_z = 1'b0;

    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            m_rem = 0;
            m_q = '0; m_r = '0; m_z = 1'b0;
        end else begin
            if (m_rem == 0) begin
                if (Start) begin
                    if (Divisor == 0) begin
                        p_q = '1; p_r = Dividend; p_z = 1'b1; m_rem = 1;
                    end else begin
                        p_q = Dividend / Divisor; p_r = Dividend % Divisor; p_z = 1'b0; m_rem = W + 1;
                    end
                end
            end else begin
                m_rem--;
            end
            if (m_rem == 1) begin
                m_q = p_q; m_r = p_r; m_z = p_z;
            end
        end
    end

    always @(negedge Clk) begin
        if (Rst_n) begin
            check("busy", int'(Busy), int'(m_rem != 0));
            check("done", int'(Done), int'(m_rem == 1));
            check("quotient", int'(Quotient), int'(m_q));
            check("remainder", int'(Remainder), int'(m_r));
            check("divbyzero", int'(DivByZero), int'(m_z));
        end
    end

    // Launch one operation with a single-cycle Start pulse and observe it.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat, output int busy_n, output int dones);
        int s;
        @(negedge Clk);
        Dividend = a; Divisor = b; Start = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        s = cyc;
        Dividend = W'($urandom);
        Divisor  = W'($urandom);
        lat = -1; busy_n = 0; dones = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            if (Busy) busy_n++;
            if (Done) begin
                dones++;
                lat = cyc - s;
            end
        end
    endtask

    task automatic wait_done(output int at_cyc, output bit ok);
        ok = 1'b0;
        at_cyc = -1;
        for (int i = 0; i < 12 && !ok; i++) begin
            @(negedge Clk);
            if (Done) begin
                ok = 1'b1;
                at_cyc = cyc;
            end
        end
    endtask

    int lat, busy_n, dones, prev_done, at_c;
    bit ok;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge Clk);
        check("reset_quotient", int'(Quotient), 0);
        check("reset_busy", int'(Busy), 0);
        check("reset_done", int'(Done), 0);
        Rst_n = 1'b1;

        run_op(4'd13, 4'd4, lat, busy_n, dones);
        check("13/4 latency", lat, 4);
        check("13/4 busy cycles", busy_n, 5);
        check("13/4 done count", dones, 1);
        check("13/4 quotient", int'(Quotient), 3);
        check("13/4 remainder", int'(Remainder), 1);
        check("13/4 divbyzero", int'(DivByZero), 0);

        run_op(4'd15, 4'd1, lat, busy_n, dones);
        check("15/1 quotient", int'(Quotient), 15);
        check("15/1 remainder", int'(Remainder), 0);
        run_op(4'd7, 4'd9, lat, busy_n, dones);
        check("7/9 quotient", int'(Quotient), 0);
        check("7/9 remainder", int'(Remainder), 7);

        run_op(4'd9, 4'd0, lat, busy_n, dones);
        check("9/0 latency", lat, 0);
        check("9/0 busy cycles", busy_n, 1);
        check("9/0 quotient", int'(Quotient), 15);
        check("9/0 remainder", int'(Remainder), 9);
        check("9/0 divbyzero", int'(DivByZero), 1);
        run_op(4'd6, 4'd3, lat, busy_n, dones);
        check("6/3 quotient", int'(Quotient), 2);
        check("6/3 remainder", int'(Remainder), 0);
        check("6/3 divbyzero", int'(DivByZero), 0);

        // Start pulse with new operands during CALC must be ignored.
        @(negedge Clk);
        Dividend = 4'd10; Divisor = 4'd3; Start = 1'b1;
        @(negedge Clk);
        Dividend = 4'd1; Divisor = 4'd1;
        @(negedge Clk);
        Start = 1'b0;
        Dividend = 4'd5; Divisor = 4'd2;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge Clk);
            if (Done) dones++;
        end
        check("ignored start done count", dones, 1);
        check("10/3 quotient held", int'(Quotient), 3);
        check("10/3 remainder held", int'(Remainder), 1);

        // Asynchronous reset in the middle of an operation.
        @(negedge Clk);
        Dividend = 4'd14; Divisor = 4'd5; Start = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        @(posedge Clk);
        @(posedge Clk);
        #2;
        Rst_n = 1'b0;
        #1;
        check("async reset quotient", int'(Quotient), 0);
        check("async reset remainder", int'(Remainder), 0);
        check("async reset busy", int'(Busy), 0);
        check("async reset done", int'(Done), 0);
        check("async reset divbyzero", int'(DivByZero), 0);
        dones = 0;
        repeat (3) begin
            @(negedge Clk);
            if (Done) dones++;
        end
        check("no done in reset", dones, 0);
        Rst_n = 1'b1;
        run_op(4'd14, 4'd5, lat, busy_n, dones);
        check("14/5 quotient", int'(Quotient), 2);
        check("14/5 remainder", int'(Remainder), 4);
        check("14/5 done count", dones, 1);

        // Random Start pulses and operand churn against the model.
        for (int i = 0; i < 300; i++) begin
            @(negedge Clk);
            Start    = ($urandom_range(0, 2) == 0);
            Dividend = W'($urandom_range(0, 15));
            Divisor  = W'($urandom_range(0, 15));
        end
        @(negedge Clk);
        Start = 1'b0;
        repeat (8) @(negedge Clk);

        // Exhaustive sweep with Start held high.
        prev_done = -1;
        Dividend = 4'd0; Divisor = 4'd0; Start = 1'b1;
        for (int p = 0; p < 256; p++) begin
            int a, b;
            a = p / 16;
            b = p % 16;
            Dividend = W'(a);
            Divisor  = W'(b);
            wait_done(at_c, ok);
            check("sweep done seen", int'(ok), 1);
            if (ok) begin
                check("sweep quotient", int'(Quotient), (b == 0) ? 15 : a / b);
                check("sweep remainder", int'(Remainder), (b == 0) ? a : a % b);
                if (prev_done >= 0)
                    check("sweep done spacing", at_c - prev_done, (b == 0) ? 2 : 6);
                prev_done = at_c;
            end
        end
        Start = 1'b0;
        repeat (8) @(negedge Clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
